// File: rtl/wb_cmd_master_if.sv
// wb_cmd_master_if: bundles the byte-stream command/response handshakes and the classic
// Wishbone initiator signals used by wb_cmd_master.
//   rx_data/rx_valid/rx_ready : command byte stream into the master
//   tx_data/tx_valid/tx_ready : response byte stream out of the master
//   wb_*                      : single-master classic Wishbone cycle signals
// Modports: master (the command engine), slave (byte source/sink plus bus target side).
interface wb_cmd_master_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;

    modport master (
        input  rx_data, rx_valid, tx_ready, wb_dat_i, wb_ack_i,
        output rx_ready, tx_data, tx_valid, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o,
               wb_stb_o
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, wb_dat_i, wb_ack_i,
        input  rx_ready, tx_data, tx_valid, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o,
               wb_stb_o
    );
endinterface

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: byte-stream driven Wishbone initiator for debug/loader access.
// Decodes big-endian command frames from a byte source, runs one classic Wishbone cycle per
// command and returns a status byte (plus read data for reads) on a byte sink.
//   Frames : 0x01 WRITE A3..A0 D3..D0 | 0x02 READ A3..A0
//   Status : 0xA5 ok, 0xEE bus timeout, 0xEF unknown opcode
// Ports:
//   clk     system clock
//   rst     synchronous reset, active-low
//   bus_io  command/response streams and Wishbone initiator (wb_cmd_master_if.master)
// Parameters:
//   TIMEOUT_CYCLES  cycles cyc/stb may be held without ack before abort (1..65535)
//   TO_W            timeout counter width, must hold TIMEOUT_CYCLES
// Optional feature macro WB_CMD_AUTOINC_EN: adds 0x11 WRNEXT (op D3..D0) and 0x12 RDNEXT (op)
// using the stored address, which advances by 4 after every successful cycle.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    wb_cmd_master_if.master  bus_io
);
    localparam logic [7:0] OpWrite = 8'h01;
    localparam logic [7:0] OpRead  = 8'h02;
`ifdef WB_CMD_AUTOINC_EN
    localparam logic [7:0] OpWrNext = 8'h11;
    localparam logic [7:0] OpRdNext = 8'h12;
`endif
    localparam logic [7:0] StsOk      = 8'hA5;
    localparam logic [7:0] StsTimeout = 8'hEE;
    localparam logic [7:0] StsBadOp   = 8'hEF;
    localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StAddr, StData, StBus, StStat, StRdat} state_e;

    state_e          state_q, state_d;
    logic [7:0]      op_q, op_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic [31:0]     rdat_q, rdat_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            rx_ready_q, rx_ready_d;
    logic            tx_valid_q, tx_valid_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic            rx_fire, tx_fire;

    function automatic logic is_write(input logic [7:0] op);
`ifdef WB_CMD_AUTOINC_EN
        return (op == OpWrite) || (op == OpWrNext);
`else
        return op == OpWrite;
`endif
    endfunction

    function automatic logic [7:0] rd_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    assign rx_fire = bus_io.rx_valid & rx_ready_q;
    assign tx_fire = tx_valid_q & bus_io.tx_ready;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rdat_d    = rdat_q;
        tx_data_d = tx_data_q;
        cnt_d     = cnt_q;
        to_d      = to_q;

        unique case (state_q)
            StIdle: begin
                if (rx_fire) begin
                    cnt_d = 2'd0;
                    to_d  = '0;
                    op_d  = bus_io.rx_data;
                    case (bus_io.rx_data)
                        OpWrite, OpRead: state_d = StAddr;
`ifdef WB_CMD_AUTOINC_EN
                        OpWrNext:        state_d = StData;
                        OpRdNext:        state_d = StBus;
`endif
                        default: begin
                            tx_data_d = StsBadOp;
                            state_d   = StStat;
                        end
                    endcase
                end
            end
            StAddr: begin
                if (rx_fire) begin
                    adr_d = {adr_q[23:0], bus_io.rx_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        to_d    = '0;
                        state_d = is_write(op_q) ? StData : StBus;
                    end
                end
            end
            StData: begin
                if (rx_fire) begin
                    dat_d = {dat_q[23:0], bus_io.rx_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        to_d    = '0;
                        state_d = StBus;
                    end
                end
            end
            StBus: begin
                // Ack takes priority over a timeout expiring on the same cycle.
                if (bus_io.wb_ack_i) begin
                    if (!is_write(op_q)) rdat_d = bus_io.wb_dat_i;
`ifdef WB_CMD_AUTOINC_EN
                    adr_d = adr_q + 32'd4;
`endif
                    tx_data_d = StsOk;
                    state_d   = StStat;
                end else if (to_q == ToLast) begin
                    tx_data_d = StsTimeout;
                    state_d   = StStat;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            StStat: begin
                if (tx_fire) begin
                    if (!is_write(op_q) && tx_data_q == StsOk) begin
                        cnt_d     = 2'd0;
                        tx_data_d = rd_byte(rdat_q, 2'd0);
                        state_d   = StRdat;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StRdat: begin
                if (tx_fire) begin
                    if (cnt_q == 2'd3) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d     = cnt_q + 2'd1;
                        tx_data_d = rd_byte(rdat_q, cnt_q + 2'd1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Handshake/bus outputs are registered from the next state so they change on the
        // edge that enters the state and stay glitch-free.
        rx_ready_d = (state_d == StIdle) || (state_d == StAddr) || (state_d == StData);
        tx_valid_d = (state_d == StStat) || (state_d == StRdat);
        cyc_d      = (state_d == StBus);
        we_d       = cyc_d && is_write(op_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            op_q       <= 8'h00;
            adr_q      <= 32'h0;
            dat_q      <= 32'h0;
            rdat_q     <= 32'h0;
            tx_data_q  <= 8'h00;
            cnt_q      <= 2'd0;
            to_q       <= '0;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rdat_q     <= rdat_d;
            tx_data_q  <= tx_data_d;
            cnt_q      <= cnt_d;
            to_q       <= to_d;
            rx_ready_q <= rx_ready_d;
            tx_valid_q <= tx_valid_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
        end
    end

    assign bus_io.rx_ready = rx_ready_q;
    assign bus_io.tx_data  = tx_data_q;
    assign bus_io.tx_valid = tx_valid_q;
    assign bus_io.wb_adr_o = adr_q;
    assign bus_io.wb_dat_o = dat_q;
    assign bus_io.wb_sel_o = 4'hF;
    assign bus_io.wb_we_o  = we_q;
    assign bus_io.wb_cyc_o = cyc_q;
    assign bus_io.wb_stb_o = cyc_q;
endmodule
